// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter and burst sequencer for the shared system bus.
// One master at a time is granted the bus. On the grant edge the arbiter
// latches that master's start virtual address and burst length. It then
// steps bus_addr by one 32-bit word for every acknowledged beat. A burst
// ends in one of two ways:
//   - the last beat is acknowledged, which pulses done;
//   - a watchdog expires with no ack, which pulses err.
// Either ending is followed by one dead turnaround cycle. Priority then
// rotates to the master just above the one that was served.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [NUM_MASTERS]         per-master level request
//   addr_in    in   [NUM_MASTERS*32]      per-master start address, master i at [32i+:32]
//   len_in     in   [NUM_MASTERS*LEN_W]   per-master burst length minus one
//   ack        in   slave accepted the current beat
//   grant      out  [NUM_MASTERS]         one-hot grant, zero when no burst is active
//   bus_valid  out  current beat on bus_addr is valid
//   bus_addr   out  [32]                  virtual word address of the current beat
//   beat_cnt   out  [LEN_W]               index of the current beat within the burst
//   done       out  one-cycle pulse when the last beat is acked
//   err        out  one-cycle pulse when the burst is aborted by the watchdog
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int LEN_W       = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_MASTERS-1:0]       req,
  input  logic [NUM_MASTERS*32-1:0]    addr_in,
  input  logic [NUM_MASTERS*LEN_W-1:0] len_in,
  input  logic                         ack,
  output logic [NUM_MASTERS-1:0]       grant,
  output logic                         bus_valid,
  output logic [31:0]                  bus_addr,
  output logic [LEN_W-1:0]             beat_cnt,
  output logic                         done,
  output logic                         err
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BURST   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // The watchdog counts idle (no-ack) cycles. The burst aborts on the cycle
  // in which it already holds TIMEOUT-1 and there is still no ack.
  localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] LAST_MASTER = PTR_W'(NUM_MASTERS - 1);

  // ---------------------------------------------------------------------------
  // Per-master views of the flattened address/length buses
  // ---------------------------------------------------------------------------
  logic [31:0]      addr_arr [NUM_MASTERS];
  logic [LEN_W-1:0] len_arr  [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi] = addr_in[32*gi +: 32];
      assign len_arr[gi]  = len_in[LEN_W*gi +: LEN_W];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]             state_reg,     state_next;
  logic [PTR_W-1:0]       ptr_reg,       ptr_next;
  logic [PTR_W-1:0]       sel_reg,       sel_next;
  logic [LEN_W-1:0]       len_reg,       len_next;
  logic [WD_W-1:0]        wd_reg,        wd_next;
  logic [NUM_MASTERS-1:0] grant_reg,     grant_next;
  logic                   bus_valid_reg, bus_valid_next;
  logic [31:0]            bus_addr_reg,  bus_addr_next;
  logic [LEN_W-1:0]       beat_cnt_reg,  beat_cnt_next;
  logic                   done_reg,      done_next;
  logic                   err_reg,       err_next;

  // ---------------------------------------------------------------------------
  // Round-robin selection
  // Scan upward from the priority pointer, wrapping modulo NUM_MASTERS. The
  // first requester found wins.
  // ---------------------------------------------------------------------------
  logic             arb_found;
  logic [PTR_W-1:0] arb_sel;
  logic [PTR_W-1:0] arb_cand;

  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_cand  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      arb_cand = PTR_W'((int'(ptr_reg) + k) % NUM_MASTERS);
      if (!arb_found && req[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
  end

  // After a burst, priority moves to the master just above the one served.
  logic [PTR_W-1:0] ptr_after_sel;
  assign ptr_after_sel = (sel_reg == LAST_MASTER) ? '0 : sel_reg + PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic end_burst;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    sel_next       = sel_reg;
    len_next       = len_reg;
    wd_next        = wd_reg;
    grant_next     = grant_reg;
    bus_valid_next = bus_valid_reg;
    bus_addr_next  = bus_addr_reg;
    beat_cnt_next  = beat_cnt_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    end_burst      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (arb_found) begin
          state_next          = ST_BURST;
          sel_next            = arb_sel;
          len_next            = len_arr[arb_sel];
          wd_next             = '0;
          grant_next          = '0;
          grant_next[arb_sel] = 1'b1;
          bus_valid_next      = 1'b1;
          bus_addr_next       = addr_arr[arb_sel];
          beat_cnt_next       = '0;
        end
      end

      ST_BURST: begin
        // Request changes from any master are ignored here. Only ack and
        // the watchdog can move the burst forward.
        if (ack) begin
          // An ack always clears the watchdog. This includes the cycle on
          // which the watchdog would otherwise have expired.
          wd_next = '0;
          if (beat_cnt_reg != len_reg) begin
            beat_cnt_next = beat_cnt_reg + LEN_W'(1);
            // Word step. Natural 32-bit overflow gives the wrap from
            // 0xFFFFFFFC to 0x00000000.
            bus_addr_next = bus_addr_reg + 32'd4;
          end else begin
            done_next = 1'b1;
            end_burst = 1'b1;
          end
        end else if (wd_reg == WD_LAST) begin
          err_next  = 1'b1;
          end_burst = 1'b1;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end

      ST_RELEASE: begin
        // Bus turnaround: one dead cycle, then arbitrate again.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // bus_addr and beat_cnt are not touched here. They keep their last
    // values until the next grant.
    if (end_burst) begin
      state_next     = ST_RELEASE;
      grant_next     = '0;
      bus_valid_next = 1'b0;
      ptr_next       = ptr_after_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // An asynchronous reset drops the grant immediately. An interrupted burst
  // leaves no done/err behind.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      sel_reg       <= '0;
      len_reg       <= '0;
      wd_reg        <= '0;
      grant_reg     <= '0;
      bus_valid_reg <= 1'b0;
      bus_addr_reg  <= '0;
      beat_cnt_reg  <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      sel_reg       <= sel_next;
      len_reg       <= len_next;
      wd_reg        <= wd_next;
      grant_reg     <= grant_next;
      bus_valid_reg <= bus_valid_next;
      bus_addr_reg  <= bus_addr_next;
      beat_cnt_reg  <= beat_cnt_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  assign grant     = grant_reg;
  assign bus_valid = bus_valid_reg;
  assign bus_addr  = bus_addr_reg;
  assign beat_cnt  = beat_cnt_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed scenarios with literal expectations, then a randomized run.
// A behavioural model tracks, per cycle:
//   - which master owns the bus;
//   - its start address and length;
//   - the current beat index;
//   - the idle-cycle count;
//   - the priority pointer.
// One compare process checks the DUT against this model on every falling
// edge while out of reset.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int TO = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [N-1:0]  req     = '0;
  logic [N*32-1:0] addr_in = '0;
  logic [N*LW-1:0] len_in  = '0;
  logic          ack     = 1'b0;
  logic [N-1:0]  grant;
  logic          bus_valid;
  logic [31:0]   bus_addr;
  logic [LW-1:0] beat_cnt;
  logic          done;
  logic          err;

  int total_checks  = 0;
  int passed_checks = 0;

  // Behavioural model. m_mode: 0 = no owner, 1 = owner transferring,
  // 2 = turnaround.
  int          m_mode = 0;
  int          m_cur  = 0;
  int          m_ptr  = 0;
  int          m_beat = 0;
  int          m_len  = 0;
  int          m_wd   = 0;
  logic [31:0] m_base = '0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;

  bus_arbiter #(
    .NUM_MASTERS(N),
    .LEN_W      (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .addr_in  (addr_in),
    .len_in   (len_in),
    .ack      (ack),
    .grant    (grant),
    .bus_valid(bus_valid),
    .bus_addr (bus_addr),
    .beat_cnt (beat_cnt),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_ptr = 0; m_beat = 0; m_len = 0; m_wd = 0;
    m_base = '0; m_done = 1'b0; m_err = 1'b0;
  endtask

  // One clock of the model, using the inputs as they stand at the edge.
  task automatic model_step();
    bit found;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_mode == 0) begin
      if (req != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && req[(m_ptr + k) % N]) begin
            found = 1'b1;
            m_cur = (m_ptr + k) % N;
          end
        end
        m_base = addr_in[32*m_cur +: 32];
        m_len  = int'(len_in[LW*m_cur +: LW]);
        m_beat = 0;
        m_wd   = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        m_wd = 0;
        if (m_beat < m_len) m_beat++;
        else begin
          m_done = 1'b1;
          m_mode = 2;
          m_ptr  = (m_cur + 1) % N;
        end
      end else if (m_wd == TO - 1) begin
        m_err  = 1'b1;
        m_mode = 2;
        m_ptr  = (m_cur + 1) % N;
      end else begin
        m_wd++;
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic set_master(input int i, input logic [31:0] a, input int l);
    addr_in[32*i +: 32] = a;
    len_in[LW*i +: LW]  = LW'(l);
  endtask

  task automatic do_reset();
    req = '0;
    ack = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    if (rst_n) begin
      eg = '0;
      if (m_mode == 1) eg[m_cur] = 1'b1;
      check("grant", 32'(grant), 32'(eg));
      check("bus_valid", 32'(bus_valid), 32'(m_mode == 1));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      if (m_mode == 1) begin
        check("bus_addr", bus_addr, m_base + 32'(4 * m_beat));
        check("beat_cnt", 32'(beat_cnt), 32'(m_beat));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int n;
    int quiet;
    logic [N-1:0] prev;
    logic [N-1:0] glog[$];
    logic [31:0] exp_s1 [4];
    logic [31:0] exp_w  [4];
    logic [N-1:0] exp_rr [5];
    exp_s1 = '{32'h0000_0020, 32'h0000_0024, 32'h0000_0028, 32'h0000_002C};
    exp_w  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    model_reset();
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(bus_valid), 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_beat", 32'(beat_cnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;

    // Single request, 4 beats, ack every cycle
    set_master(0, 32'h20, 3);
    req = 4'b0001;
    ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b == 0) check("s1_grant", 32'(grant), 32'h1);
      check("s1_addr", bus_addr, exp_s1[b]);
      check("s1_beat", 32'(beat_cnt), 32'(b));
    end
    tick();
    check("s1_done", 32'(done), 32'h1);
    check("s1_grant_drop", 32'(grant), 32'h0);
    req = '0;
    tick();
    check("s1_done_pulse", 32'(done), 32'h0);
    check("s1_dead_valid", 32'(bus_valid), 32'h0);

    // Round-robin with all four requesting
    do_reset();
    set_master(0, 32'h0000_0020, 0);
    set_master(1, 32'h0080_00A0, 0);
    set_master(2, 32'h0100_0009, 0);
    set_master(3, 32'h0100_001C, 0);
    req = 4'b1111;
    ack = 1'b1;
    glog.delete();
    prev = '0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (grant != '0 && prev == '0) glog.push_back(grant);
      prev = grant;
    end
    check("rr_count", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) check("rr_order", 32'(glog[i]), 32'(exp_rr[i]));
    req = '0;
    tick();
    tick();
    tick();

    // Watchdog timeout on master 2, then master 3 is served
    do_reset();
    set_master(2, 32'h0100_0000, 1);
    set_master(3, 32'h0000_0300, 0);
    req = 4'b1100;
    ack = 1'b0;
    tick();
    check("to_grant", 32'(grant), 32'b0100);
    n = 0;
    while (!err && n < 40) begin tick(); n++; end
    check("to_err_latency", 32'(n), 32'(TO));
    check("to_grant_drop", 32'(grant), 32'h0);
    req = 4'b1000;
    n = 0;
    while (grant == '0 && n < 10) begin tick(); n++; end
    check("to_next_latency", 32'(n), 32'd2);
    check("to_next_grant", 32'(grant), 32'b1000);
    ack = 1'b1;
    tick();
    tick();
    req = '0;
    tick();
    tick();

    // Ack arriving on the cycle the watchdog would expire
    do_reset();
    set_master(0, 32'h100, 1);
    req = 4'b0001;
    ack = 1'b0;
    tick();
    check("race_grant", 32'(grant), 32'h1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("race_no_err_early", 32'(err), 32'h0);
    end
    ack = 1'b1;
    tick();
    check("race_no_err", 32'(err), 32'h0);
    check("race_beat", 32'(beat_cnt), 32'h1);
    check("race_addr", bus_addr, 32'h104);
    check("race_valid", 32'(bus_valid), 32'h1);
    ack = 1'b0;
    n = 0;
    while (!err && n < 40) begin tick(); n++; end
    check("race_wd_restart", 32'(n), 32'(TO));
    req = '0;
    tick();
    tick();

    // Address wrap across 2^32
    do_reset();
    set_master(0, 32'hFFFF_FFF8, 3);
    req = 4'b0001;
    ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick();
      check("wrap_addr", bus_addr, exp_w[b]);
    end
    tick();
    check("wrap_done", 32'(done), 32'h1);
    req = '0;
    tick();
    tick();

    // Asynchronous reset in the middle of a burst
    do_reset();
    set_master(0, 32'h40, 3);
    set_master(1, 32'h200, 0);
    set_master(2, 32'h300, 0);
    req = 4'b0001;
    ack = 1'b1;
    tick();
    tick();
    tick();
    check("ar_beat_before", 32'(beat_cnt), 32'h2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_valid", 32'(bus_valid), 32'h0);
    check("ar_beat", 32'(beat_cnt), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ar_no_done", 32'(done), 32'h0);
      check("ar_no_err", 32'(err), 32'h0);
    end
    rst_n = 1'b1;
    req = 4'b0110;
    ack = 1'b0;
    tick();
    check("ar_next_grant", 32'(grant), 32'b0010);
    ack = 1'b1;
    tick();
    req = '0;
    tick();
    tick();

    // Randomized traffic, including ack droughts long enough to time out
    do_reset();
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0)
          set_master(i, $urandom, int'($urandom_range(0, (1 << LW) - 1)));
      if (quiet > 0) begin
        ack = 1'b0;
        quiet--;
      end else if ($urandom_range(0, 40) == 0) begin
        quiet = int'($urandom_range(10, 20));
        ack = 1'b0;
      end else begin
        ack = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
